// File: rtl/sprite_drawer.sv
// Raster pixel generator for a VGA frame-buffer adapter: clears the whole screen or fills a
// sprite-sized rectangle, one pixel per clock, clipping off-screen pixels without shortening the draw.
module sprite_drawer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] obj_x,
    input  logic [6:0] obj_y,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int MAX_W = (SCREEN_W > SPRITE_W) ? SCREEN_W : SPRITE_W;
    localparam int MAX_H = (SCREEN_H > SPRITE_H) ? SCREEN_H : SPRITE_H;
    localparam int IW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int JW    = (MAX_H > 1) ? $clog2(MAX_H) : 1;
    // Coordinate sums are one bit wider than the wider operand so off-screen never aliases on-screen.
    localparam int XSW   = ((IW > 8) ? IW : 8) + 1;
    localparam int YSW   = ((JW > 7) ? JW : 7) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     r_state;
    logic [IW-1:0]  r_i;
    logic [JW-1:0]  r_j;
    logic           r_mode;
    logic [7:0]     r_obj_x;
    logic [6:0]     r_obj_y;
    logic [2:0]     r_colour;

    logic [IW-1:0]  w_i_max;
    logic [JW-1:0]  w_j_max;
    logic           w_last_i;
    logic           w_last_j;
    logic [XSW-1:0] w_px;
    logic [YSW-1:0] w_py;
    logic           w_on_screen;

    always_comb begin
        w_i_max  = r_mode ? IW'(SPRITE_W - 1) : IW'(SCREEN_W - 1);
        w_j_max  = r_mode ? JW'(SPRITE_H - 1) : JW'(SCREEN_H - 1);
        w_last_i = (r_i == w_i_max);
        w_last_j = (r_j == w_j_max);
        w_px     = r_mode ? (XSW'(r_obj_x) + XSW'(r_i)) : XSW'(r_i);
        w_py     = r_mode ? (YSW'(r_obj_y) + YSW'(r_j)) : YSW'(r_j);
        w_on_screen = (w_px < XSW'(SCREEN_W)) && (w_py < YSW'(SCREEN_H));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_i      <= '0;
            r_j      <= '0;
            r_mode   <= 1'b0;
            r_obj_x  <= '0;
            r_obj_y  <= '0;
            r_colour <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_DRAW;
                        r_mode   <= mode;
                        r_obj_x  <= obj_x;
                        r_obj_y  <= obj_y;
                        r_colour <= colour_in;
                        r_i      <= '0;
                        r_j      <= '0;
                    end
                end
                S_DRAW: begin
                    // Counters stay on the final pixel so x/y hold it after the draw ends.
                    if (w_last_i && w_last_j) begin
                        r_state <= S_DONE;
                    end else if (w_last_i) begin
                        r_i <= '0;
                        r_j <= r_j + JW'(1);
                    end else begin
                        r_i <= r_i + IW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        x      = w_px[7:0];
        y      = w_py[6:0];
        colour = r_colour;
        plot   = (r_state == S_DRAW) && w_on_screen;
        busy   = (r_state == S_DRAW) || (r_state == S_DONE);
        done   = (r_state == S_DONE);
    end

endmodule

// File: doc/sprite_drawer.md
SPRITE_DRAWER -- requirements
Module: sprite_drawer

Interface
REQ-001 Parameter SCREEN_W, default 160, visible width in pixels.
REQ-002 Parameter SCREEN_H, default 120, visible height in pixels.
REQ-003 Parameter SPRITE_W, default 8, sprite width in pixels.
REQ-004 Parameter SPRITE_H, default 8, sprite height in pixels.
REQ-005 clk  input  1  system clock, 50 MHz; the only clock.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-007 start  input  1  draw request, sampled only in IDLE.
REQ-008 mode  input  1  0 = clear whole screen, 1 = draw sprite rectangle.
REQ-009 obj_x  input  8  sprite top-left x, latched at accepted start.
REQ-010 obj_y  input  7  sprite top-left y, latched at accepted start.
REQ-011 colour_in  input  3  fill colour, latched at accepted start.
REQ-012 x  output  8  current pixel x to VGA adapter.
REQ-013 y  output  7  current pixel y to VGA adapter.
REQ-014 colour  output  3  current pixel colour.
REQ-015 plot  output  1  pixel write strobe; high for exactly one cycle per written pixel.
REQ-016 busy  output  1  high in DRAW and DONE.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have states IDLE, DRAW and DONE.
REQ-019 IDLE -> DRAW on a rising edge with start=1; mode, obj_x, obj_y and colour_in SHALL be latched on that edge and the column/row counters cleared to 0.
REQ-020 start SHALL be ignored in DRAW and DONE; latched values SHALL NOT change until the next accepted start.
REQ-021 In DRAW the block SHALL visit exactly one pixel per cycle in raster order: column counter i fastest, row counter j next, both from 0.
REQ-022 Mode 1: the region SHALL be SPRITE_W x SPRITE_H; the pixel coordinate SHALL be (obj_x+i, obj_y+j), computed at least 1 bit wider than the port so overflow is detected and never wraps.
REQ-023 Mode 0: the region SHALL be SCREEN_W x SCREEN_H; the pixel coordinate SHALL be (i, j), ignoring obj_x and obj_y.
REQ-024 plot SHALL be 1 only in DRAW and only when the pixel satisfies x < SCREEN_W and y < SCREEN_H; off-screen pixels SHALL have plot=0 but still consume their cycle (clipping, fixed duration).
REQ-025 x, y and colour SHALL be functions of registered state only, with no combinational path from any input; colour SHALL equal the latched colour_in.
REQ-026 After the last pixel of the region (i=W-1, j=H-1) the FSM SHALL go DRAW -> DONE; DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 Latency: an accepted start at edge 0 SHALL give the first pixel during cycle 1, the last pixel during cycle W*H, and done=1 during cycle W*H+1.
REQ-028 A start held high through DONE SHALL be accepted on the first IDLE cycle after it, giving back-to-back draws with exactly one IDLE cycle between them.
REQ-029 Outside DRAW, plot SHALL be 0; x and y SHALL hold their last values.

Reset
REQ-030 On reset=1 the block SHALL enter IDLE, clear i, j and all latches to 0, and drive x=0, y=0, colour=0, plot=0, busy=0, done=0 from the next cycle.
REQ-031 Reset SHALL take priority over start and SHALL abort a draw in progress immediately with no done pulse.

Verification
REQ-032 mode=1, obj_x=10, obj_y=20, colour_in=3'b101, start pulse -> 64 plot cycles, first (10,20), last (17,27), colour 101 throughout, done one cycle after the last pixel.
REQ-033 mode=1, obj_x=156, obj_y=116 -> still 64 DRAW cycles; plot only for x in 156..159 and y in 116..119 (16 pulses); no x/y wrap-around.
REQ-034 mode=0, colour_in=3'b000 -> 19200 consecutive plot cycles, first (0,0), last (159,119), then a done pulse.
REQ-035 start pulsed again during DRAW with obj_x=50 -> ignored; the remaining pixels keep the original obj_x; exactly one done pulse.
REQ-036 reset asserted at DRAW pixel 30 -> next cycle plot=0, busy=0, x=0, y=0, no done; a fresh start then draws the full 64 pixels.
REQ-037 start held high continuously with mode=1 -> repeated draws of 64 pixels with done, one IDLE cycle, then the next first pixel.
